// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore-style control unit for a shared-memory multi-cycle MIPS datapath.
// Memory accesses (instruction fetch, load, store) use a MEM_REQ/MEM_READY
// handshake and are abandoned into a sticky error state when MEM_READY does
// not arrive within MEM_TIMEOUT cycles (MEM_TIMEOUT = 0 waits forever).
//
// Optional feature macro: MIPS_IMM_ALU_EN
//   defined   -> addi/andi/ori run through IEXEC(10) and IWB(11)
//   undefined -> those opcodes are treated as illegal (pulse + back to FETCH)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int WAIT_CNT_W  = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [5:0] OPCODE,
    input  logic       MEM_READY,
    output logic       MEM_REQ,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [3:0] STATE,
    output logic       ILLEGAL_OP,
    output logic       MEM_ERR
);

    // Opcode field values decoded in DECODE and MEMADR
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_IMM_ALU_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    // Timeout fires on the last counted cycle; a zero timeout never fires
    localparam bit                    TIMEOUT_EN   = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST =
        WAIT_CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE      = WAIT_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0] CNT_MAX      = '1;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
`ifdef MIPS_IMM_ALU_EN
        IEXEC  = 4'd10,
        IWB    = 4'd11,
`endif
        ERR    = 4'd15
    } state_t;

    // Moore control word; IRWrite and the fetch-time PCWrite are handled
    // separately because they depend on MEM_READY.
    typedef struct packed {
        logic       memReq;
        logic       memRead;
        logic       memWrite;
        logic       iorD;
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       regWrite;
        logic       regDst;
        logic       memtoReg;
    } ctrl_t;

    state_t                r_state;
    ctrl_t                 r_ctrl;
    logic [WAIT_CNT_W-1:0] r_waitCnt;
    logic                  r_memErr;

    state_t w_nextState;
    logic   w_waitState;
    logic   w_timeout;
    logic   w_decodedOp;
    logic   w_inFetch;

    // Control word asserted while the FSM sits in a given state
    function automatic ctrl_t decodeCtrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memReq  = 1'b1;
                c.memRead = 1'b1;
                c.aluSrcB = 2'b01;
            end
            DECODE: begin
                c.aluSrcB = 2'b11;
            end
            MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            MEMRD: begin
                c.memReq  = 1'b1;
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            MEMWB: begin
                c.regWrite = 1'b1;
                c.memtoReg = 1'b1;
            end
            MEMWR: begin
                c.memReq   = 1'b1;
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = 2'b10;
            end
            RWB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b1;
            end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluOp       = 2'b01;
                c.pcWriteCond = 1'b1;
                c.pcSource    = 2'b01;
            end
            JUMP: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'b10;
            end
`ifdef MIPS_IMM_ALU_EN
            IEXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                c.aluOp   = 2'b11;
            end
            IWB: begin
                c.regWrite = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    assign w_inFetch   = (r_state == FETCH);
    assign w_waitState = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    assign w_timeout   = TIMEOUT_EN && (r_waitCnt == TIMEOUT_LAST) && !MEM_READY;

    // Flag opcodes this build knows how to execute
    always_comb begin
        case (OPCODE)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: w_decodedOp = 1'b1;
`ifdef MIPS_IMM_ALU_EN
            OP_ADDI, OP_ANDI, OP_ORI:             w_decodedOp = 1'b1;
`endif
            default:                              w_decodedOp = 1'b0;
        endcase
    end

    // Next-state selection; MEM_READY wins over a same-cycle timeout
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FETCH: begin
                if (MEM_READY)      w_nextState = DECODE;
                else if (w_timeout) w_nextState = ERR;
            end
            DECODE: begin
                case (OPCODE)
                    OP_LW, OP_SW:             w_nextState = MEMADR;
                    OP_RTYPE:                 w_nextState = EXEC;
                    OP_BEQ:                   w_nextState = BRANCH;
                    OP_J:                     w_nextState = JUMP;
`ifdef MIPS_IMM_ALU_EN
                    OP_ADDI, OP_ANDI, OP_ORI: w_nextState = IEXEC;
`endif
                    default:                  w_nextState = FETCH;
                endcase
            end
            MEMADR:  w_nextState = (OPCODE == OP_SW) ? MEMWR : MEMRD;
            MEMRD: begin
                if (MEM_READY)      w_nextState = MEMWB;
                else if (w_timeout) w_nextState = ERR;
            end
            MEMWB:   w_nextState = FETCH;
            MEMWR: begin
                if (MEM_READY)      w_nextState = FETCH;
                else if (w_timeout) w_nextState = ERR;
            end
            EXEC:    w_nextState = RWB;
            RWB:     w_nextState = FETCH;
            BRANCH:  w_nextState = FETCH;
            JUMP:    w_nextState = FETCH;
`ifdef MIPS_IMM_ALU_EN
            IEXEC:   w_nextState = IWB;
            IWB:     w_nextState = FETCH;
`endif
            ERR:     w_nextState = ERR;
            default: w_nextState = FETCH;
        endcase
    end

    // State, registered control word, saturating wait counter and sticky error
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= FETCH;
            r_ctrl    <= decodeCtrl(FETCH);
            r_waitCnt <= '0;
            r_memErr  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_ctrl  <= decodeCtrl(w_nextState);
            if (w_nextState != r_state) begin
                r_waitCnt <= '0;
            end else if (w_waitState && !MEM_READY && (r_waitCnt != CNT_MAX)) begin
                r_waitCnt <= r_waitCnt + CNT_ONE;
            end
            if (w_nextState == ERR) begin
                r_memErr <= 1'b1;
            end
        end
    end

    // Every strobe is forced low while reset is held, without waiting for CLK
    assign MEM_REQ     = RESET_N & r_ctrl.memReq;
    assign MemRead     = RESET_N & r_ctrl.memRead;
    assign MemWrite    = RESET_N & r_ctrl.memWrite;
    assign IorD        = RESET_N & r_ctrl.iorD;
    assign IRWrite     = RESET_N & w_inFetch & MEM_READY;
    assign PCWrite     = RESET_N & (r_ctrl.pcWrite | (w_inFetch & MEM_READY));
    assign PCWriteCond = RESET_N & r_ctrl.pcWriteCond;
    assign PCSource    = {2{RESET_N}} & r_ctrl.pcSource;
    assign ALUOp       = {2{RESET_N}} & r_ctrl.aluOp;
    assign ALUSrcA     = RESET_N & r_ctrl.aluSrcA;
    assign ALUSrcB     = {2{RESET_N}} & r_ctrl.aluSrcB;
    assign RegWrite    = RESET_N & r_ctrl.regWrite;
    assign RegDst      = RESET_N & r_ctrl.regDst;
    assign MemtoReg    = RESET_N & r_ctrl.memtoReg;
    assign STATE       = r_state;
    assign ILLEGAL_OP  = RESET_N & (r_state == DECODE) & ~w_decodedOp;
    assign MEM_ERR     = r_memErr;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Self-checking bench: each scenario builds the expected per-cycle state
// trace of an instruction from its class and memory wait lengths, then
// compares STATE and every control output cycle by cycle.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int TIMEOUT = 4;
`ifdef MIPS_IMM_ALU_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    logic       CLK;
    logic       RESET_N;
    logic [5:0] OPCODE;
    logic       MEM_READY;
    logic       MEM_REQ, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, MemtoReg;
    logic [3:0] STATE;
    logic       ILLEGAL_OP, MEM_ERR;
    logic [18:0] obsCtrl;

    int testsRun    = 0;
    int testsFailed = 0;
    int expState[$];
    bit expReady[$];
    bit expErr;

    mips_multicycle_ctrl #(
        .MEM_TIMEOUT(TIMEOUT),
        .WAIT_CNT_W (8)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .OPCODE     (OPCODE),
        .MEM_READY  (MEM_READY),
        .MEM_REQ    (MEM_REQ),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .STATE      (STATE),
        .ILLEGAL_OP (ILLEGAL_OP),
        .MEM_ERR    (MEM_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign obsCtrl = {MEM_REQ, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                      PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, MemtoReg,
                      ILLEGAL_OP, MEM_ERR};

    // Opcodes the control unit executes in this build
    function automatic bit isLegal(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW || op == OP_RTYPE || op == OP_BEQ || op == OP_J)
            return 1'b1;
        if (IMM_EN && (op == OP_ADDI || op == OP_ANDI || op == OP_ORI))
            return 1'b1;
        return 1'b0;
    endfunction

    // Expected outputs for a state number, taken from the state table
    function automatic logic [18:0] expCtrl(input int st, input bit rdy, input logic [5:0] op);
        logic memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond;
        logic [1:0] pcSource, aluOp, aluSrcB;
        logic aluSrcA, regWrite, regDst, memtoReg, illegal, memErr;
        {memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond} = 7'b0;
        {pcSource, aluOp, aluSrcB} = 6'b0;
        {aluSrcA, regWrite, regDst, memtoReg, illegal, memErr} = 6'b0;
        case (st)
            0:  begin memReq = 1; memRead = 1; aluSrcB = 2'b01; irWrite = rdy; pcWrite = rdy; end
            1:  begin aluSrcB = 2'b11; illegal = !isLegal(op); end
            2:  begin aluSrcA = 1; aluSrcB = 2'b10; end
            3:  begin memReq = 1; memRead = 1; iorD = 1; end
            4:  begin regWrite = 1; memtoReg = 1; end
            5:  begin memReq = 1; memWrite = 1; iorD = 1; end
            6:  begin aluSrcA = 1; aluOp = 2'b10; end
            7:  begin regWrite = 1; regDst = 1; end
            8:  begin aluSrcA = 1; aluOp = 2'b01; pcWriteCond = 1; pcSource = 2'b01; end
            9:  begin pcWrite = 1; pcSource = 2'b10; end
            10: begin aluSrcA = 1; aluSrcB = 2'b10; aluOp = 2'b11; end
            11: begin regWrite = 1; end
            15: begin memErr = 1; end
            default: ;
        endcase
        return {memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond,
                pcSource, aluOp, aluSrcA, aluSrcB, regWrite, regDst, memtoReg, illegal, memErr};
    endfunction

    task automatic addFixed(input int st);
        expState.push_back(st);
        expReady.push_back(1'($urandom));
    endtask

    // Memory wait: ready arrives after waitCycles low cycles unless the timeout hits first
    task automatic addWait(input int st, input int waitCycles);
        for (int k = 0; k <= waitCycles; k++) begin
            if (k == waitCycles) begin
                expState.push_back(st); expReady.push_back(1'b1);
            end else if (TIMEOUT != 0 && k == TIMEOUT - 1) begin
                expState.push_back(st); expReady.push_back(1'b0);
                expErr = 1'b1;
                break;
            end else begin
                expState.push_back(st); expReady.push_back(1'b0);
            end
        end
    endtask

    // Expected cycle-by-cycle state trace of one instruction
    task automatic buildExpect(input logic [5:0] op, input int fWait, input int mWait);
        expState.delete();
        expReady.delete();
        expErr = 1'b0;
        addWait(0, fWait);
        if (!expErr) begin
            addFixed(1);
            if (op == OP_LW) begin
                addFixed(2); addWait(3, mWait);
                if (!expErr) addFixed(4);
            end else if (op == OP_SW) begin
                addFixed(2); addWait(5, mWait);
            end else if (op == OP_RTYPE) begin
                addFixed(6); addFixed(7);
            end else if (op == OP_BEQ) begin
                addFixed(8);
            end else if (op == OP_J) begin
                addFixed(9);
            end else if (IMM_EN && (op == OP_ADDI || op == OP_ANDI || op == OP_ORI)) begin
                addFixed(10); addFixed(11);
            end
        end
        if (expErr) repeat (3) addFixed(15);
    endtask

    task automatic test_reset();
        MEM_READY = 1'b1;
        #3;
        testsRun++;
        if (STATE !== 4'd0 || obsCtrl !== 19'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: state %0d ctrl %b, expected state 0 ctrl all zero", STATE, obsCtrl);
        end
        @(posedge CLK); @(negedge CLK);
        RESET_N   = 1'b1;
        MEM_READY = 1'b0;
        #1;
        testsRun++;
        if (STATE !== 4'd0 || obsCtrl !== expCtrl(0, 1'b0, OPCODE)) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: state %0d ctrl %b, expected state 0 ctrl %b",
                     STATE, obsCtrl, expCtrl(0, 1'b0, OPCODE));
        end
    endtask

    task automatic test_rtype();
        logic [5:0] op = OP_RTYPE;
        buildExpect(op, 0, 0);
        for (int i = 0; i < expState.size(); i++) begin
            OPCODE    = (expState[i] == 0) ? 6'($urandom) : op;
            MEM_READY = expReady[i];
            #1;
            testsRun++;
            if (STATE !== 4'(expState[i])) begin
                testsFailed++;
                $display("[TB] FAIL rtype_state cyc %0d: got %0d expected %0d", i, STATE, expState[i]);
            end
            testsRun++;
            if (obsCtrl !== expCtrl(expState[i], expReady[i], op)) begin
                testsFailed++;
                $display("[TB] FAIL rtype_ctrl cyc %0d: got %b expected %b", i, obsCtrl,
                         expCtrl(expState[i], expReady[i], op));
            end
            @(posedge CLK); @(negedge CLK);
        end
    endtask

    task automatic test_lw_wait();
        logic [5:0] op = OP_LW;
        for (int n = 0; n < 3; n++) begin
            if (n == 0) buildExpect(op, 0, 3);
            else        buildExpect(op, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1));
            for (int i = 0; i < expState.size(); i++) begin
                OPCODE    = (expState[i] == 0) ? 6'($urandom) : op;
                MEM_READY = expReady[i];
                #1;
                testsRun++;
                if (STATE !== 4'(expState[i])) begin
                    testsFailed++;
                    $display("[TB] FAIL lw_state run %0d cyc %0d: got %0d expected %0d", n, i, STATE, expState[i]);
                end
                testsRun++;
                if (obsCtrl !== expCtrl(expState[i], expReady[i], op)) begin
                    testsFailed++;
                    $display("[TB] FAIL lw_ctrl run %0d cyc %0d: got %b expected %b", n, i, obsCtrl,
                             expCtrl(expState[i], expReady[i], op));
                end
                @(posedge CLK); @(negedge CLK);
            end
        end
    endtask

    task automatic test_illegal_and_imm();
        logic [5:0] ops[5] = '{6'b111111, OP_ADDI, OP_ANDI, OP_ORI, 6'b010101};
        foreach (ops[k]) begin
            buildExpect(ops[k], $urandom_range(0, 2), 0);
            for (int i = 0; i < expState.size(); i++) begin
                OPCODE    = (expState[i] == 0) ? 6'($urandom) : ops[k];
                MEM_READY = expReady[i];
                #1;
                testsRun++;
                if (STATE !== 4'(expState[i])) begin
                    testsFailed++;
                    $display("[TB] FAIL op%b_state cyc %0d: got %0d expected %0d", ops[k], i, STATE, expState[i]);
                end
                testsRun++;
                if (obsCtrl !== expCtrl(expState[i], expReady[i], ops[k])) begin
                    testsFailed++;
                    $display("[TB] FAIL op%b_ctrl cyc %0d: got %b expected %b", ops[k], i, obsCtrl,
                             expCtrl(expState[i], expReady[i], ops[k]));
                end
                @(posedge CLK); @(negedge CLK);
            end
        end
    endtask

    task automatic test_sw_timeout();
        logic [5:0] op = OP_SW;
        buildExpect(op, 0, TIMEOUT + 2);
        for (int i = 0; i < expState.size(); i++) begin
            OPCODE    = (expState[i] == 0) ? 6'($urandom) : op;
            MEM_READY = expReady[i];
            #1;
            testsRun++;
            if (STATE !== 4'(expState[i])) begin
                testsFailed++;
                $display("[TB] FAIL sw_to_state cyc %0d: got %0d expected %0d", i, STATE, expState[i]);
            end
            testsRun++;
            if (obsCtrl !== expCtrl(expState[i], expReady[i], op)) begin
                testsFailed++;
                $display("[TB] FAIL sw_to_ctrl cyc %0d: got %b expected %b", i, obsCtrl,
                         expCtrl(expState[i], expReady[i], op));
            end
            @(posedge CLK); @(negedge CLK);
        end
        #2 RESET_N = 1'b0;
        #1;
        testsRun++;
        if (STATE !== 4'd0 || obsCtrl !== 19'b0) begin
            testsFailed++;
            $display("[TB] FAIL sw_to_reset: state %0d ctrl %b, expected state 0 ctrl all zero", STATE, obsCtrl);
        end
        @(negedge CLK);
        RESET_N   = 1'b1;
        MEM_READY = 1'b0;
        #1;
        testsRun++;
        if (STATE !== 4'd0 || obsCtrl !== expCtrl(0, 1'b0, OPCODE)) begin
            testsFailed++;
            $display("[TB] FAIL sw_to_release: state %0d ctrl %b expected %b", STATE, obsCtrl, expCtrl(0, 1'b0, OPCODE));
        end
    endtask

    task automatic test_reset_during_write();
        logic [5:0] op = OP_SW;
        buildExpect(op, 0, TIMEOUT + 2);
        for (int i = 0; i < 4; i++) begin
            OPCODE    = (expState[i] == 0) ? 6'($urandom) : op;
            MEM_READY = expReady[i];
            #1;
            testsRun++;
            if (STATE !== 4'(expState[i]) || obsCtrl !== expCtrl(expState[i], expReady[i], op)) begin
                testsFailed++;
                $display("[TB] FAIL rst_wr_pre cyc %0d: state %0d ctrl %b expected state %0d ctrl %b", i,
                         STATE, obsCtrl, expState[i], expCtrl(expState[i], expReady[i], op));
            end
            @(posedge CLK); @(negedge CLK);
        end
        MEM_READY = 1'b0;
        #1;
        testsRun++;
        if (MemWrite !== 1'b1 || MEM_REQ !== 1'b1 || STATE !== 4'd5) begin
            testsFailed++;
            $display("[TB] FAIL rst_wr_active: MemWrite %b MEM_REQ %b state %0d, expected 1 1 5", MemWrite, MEM_REQ, STATE);
        end
        #1 RESET_N = 1'b0;
        #1;
        testsRun++;
        if (MemWrite !== 1'b0 || MEM_REQ !== 1'b0 || STATE !== 4'd0 || obsCtrl !== 19'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_wr_async: MemWrite %b MEM_REQ %b state %0d ctrl %b, expected all zero",
                     MemWrite, MEM_REQ, STATE, obsCtrl);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        testsRun++;
        if (STATE !== 4'd0 || obsCtrl !== expCtrl(0, 1'b0, OPCODE)) begin
            testsFailed++;
            $display("[TB] FAIL rst_wr_refetch: state %0d ctrl %b expected %b", STATE, obsCtrl, expCtrl(0, 1'b0, OPCODE));
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] op;
        logic [5:0] pool[7] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 6)];
            buildExpect(op,
                        ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 2),
                        $urandom_range(0, TIMEOUT + 1));
            for (int i = 0; i < expState.size(); i++) begin
                OPCODE    = (expState[i] == 0) ? 6'($urandom) : op;
                MEM_READY = expReady[i];
                #1;
                testsRun++;
                if (STATE !== 4'(expState[i])) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_state instr %0d op %b cyc %0d: got %0d expected %0d",
                             n, op, i, STATE, expState[i]);
                end
                testsRun++;
                if (obsCtrl !== expCtrl(expState[i], expReady[i], op)) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_ctrl instr %0d op %b cyc %0d: got %b expected %b",
                             n, op, i, obsCtrl, expCtrl(expState[i], expReady[i], op));
                end
                @(posedge CLK); @(negedge CLK);
            end
            if (expErr) begin
                #2 RESET_N = 1'b0;
                #1;
                testsRun++;
                if (STATE !== 4'd0 || MEM_ERR !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_err_clear instr %0d: state %0d MEM_ERR %b, expected 0 0", n, STATE, MEM_ERR);
                end
                @(negedge CLK);
                RESET_N = 1'b1;
            end
        end
        MEM_READY = 1'b0;
        #1;
        testsRun++;
        if (STATE !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_final_state: got %0d expected 0", STATE);
        end
    endtask

    // Scenario sequence
    initial begin
        RESET_N   = 1'b0;
        OPCODE    = 6'd0;
        MEM_READY = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_illegal_and_imm();
        test_sw_timeout();
        test_reset_during_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle MIPS control unit, the next generation of the single-cycle control path. It drives a shared-memory multi-cycle datapath (IR, MDR, A, B and ALUOut registers) through a Moore FSM. Memory accesses use a variable-latency handshake (MEM_REQ/MEM_READY) with a programmable timeout. The block sits between the instruction register's opcode field and every datapath mux and enable.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for MEM_READY per access; 0 disables the timeout
WAIT_CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous reset, active-low
OPCODE  in  6  IR[31:26]
MEM_READY  in  1  memory has completed the current access this cycle
MEM_REQ  out  1  memory access in progress
MemRead  out  1  read strobe
MemWrite  out  1  write strobe
IorD  out  1  0: address = PC; 1: address = ALUOut
IRWrite  out  1  load IR
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
PCSource  out  2  00: ALU; 01: ALUOut; 10: jump target
ALUOp  out  2  00 add; 01 sub; 10 funct; 11 immediate (downstream ALU_control decodes OPCODE[2:0])
ALUSrcA  out  1  0: PC; 1: A
ALUSrcB  out  2  00: B; 01: 4; 10: sign-extended imm; 11: sign-extended imm<<2
RegWrite  out  1  register file write
RegDst  out  1  0: rt; 1: rd
MemtoReg  out  1  0: ALUOut; 1: MDR
STATE  out  4  current state (debug)
ILLEGAL_OP  out  1  one-cycle pulse on an undecoded opcode
MEM_ERR  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, RESET_N=0):
  - State = FETCH(0); wait counter = 0; MEM_ERR = 0.
  - All control outputs forced to 0 combinationally while RESET_N=0. STATE reads 0.
  - Reset mid-access abandons the access; no write strobe survives reset.
- Outputs are Moore-decoded from state, except IRWrite/PCWrite in FETCH, which are additionally gated by MEM_READY.
- States and transitions:
  - FETCH(0): MEM_REQ, MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. Held until MEM_READY=1. In the MEM_READY cycle: IRWrite=1, PCWrite=1, next state DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Dispatch on OPCODE:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - immediate opcodes -> IEXEC (optional feature)
    - otherwise: ILLEGAL_OP=1 for this cycle, next FETCH (instruction acts as NOP)
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMRD for lw, MEMWR for sw.
  - MEMRD(3): MEM_REQ, MemRead, IorD=1. Wait for MEM_READY, then MEMWB.
  - MEMWB(4): RegWrite, RegDst=0, MemtoReg=1. Next FETCH.
  - MEMWR(5): MEM_REQ, MemWrite, IorD=1. Wait for MEM_READY, then FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
  - RWB(7): RegWrite, RegDst=1, MemtoReg=0. Next FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
  - JUMP(9): PCWrite=1, PCSource=10. Next FETCH.
  - ERR(15): all control outputs 0, MEM_ERR=1. Held until reset.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle in those states while MEM_READY=0.
  - If MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT-1 with MEM_READY=0, next state is ERR.
  - MEM_READY=1 in that same cycle wins: the access completes normally.
  - The counter saturates and never wraps.
- MEM_READY sampled outside the wait states (FETCH, MEMRD, MEMWR) is ignored.
- Latency with MEM_READY tied high (cycles per instruction):
  - lw: 5
  - sw, R-type, immediate: 4
  - beq, j: 3
  - illegal opcode: 2

Optional Feature:
- Macro: MIPS_IMM_ALU_EN.
- Defined: opcodes 001000 (addi), 001100 (andi) and 001101 (ori) dispatch from DECODE to two extra states:
  - IEXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next IWB.
  - IWB(11): RegWrite, RegDst=0, MemtoReg=0. Next FETCH.
- Undefined: states 10 and 11 are absent, and these opcodes take the illegal path (ILLEGAL_OP pulse, back to FETCH).

Test Plan:
- Reset then MEM_READY=1 constantly, OPCODE=000000 -> STATE sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; IRWrite/PCWrite high for exactly 1 cycle in state 0.
- lw (100011), MEM_READY low 3 cycles in MEMRD then high -> sequence 0,1,2,3,3,3,3,4,0; MemRead and IorD=1 held throughout state 3; MemtoReg=1 in state 4.
- sw (101011) with MEM_TIMEOUT=4, MEM_READY never asserted in MEMWR -> ERR after 4 cycles in state 5; MEM_ERR=1 and MemWrite=0 persist; RESET_N pulse returns STATE=0 and clears MEM_ERR.
- OPCODE=111111 -> ILLEGAL_OP high for exactly the DECODE cycle; next STATE=0; no RegWrite/MemWrite/PCWrite issued beyond the fetch.
- addi (001000): with MIPS_IMM_ALU_EN -> 0,1,10,11,0 with ALUOp=11 in state 10; without the macro -> ILLEGAL_OP pulse and 0,1,0.
- RESET_N dropped during MEMWR with MemWrite high -> MemWrite, MEM_REQ and STATE go to 0 in the same cycle without waiting for CLK; first FETCH request appears after release.
